// File: rtl/mips_mc_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master = controller side (decodes op/funct/zero, drives selects and enables).
interface mips_mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, alucontrol, pcsrc, pcen, state
  );

  modport slave (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, alucontrol, pcsrc, pcen, state
  );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing one ALU, one memory port and the regfile.
// Define MIPS_MC_BNE_EN to add the BNE branch state (op 000101).
module mips_mc_controller (
  input  logic                 clk,
  input  logic                 reset,
  mips_mc_controller_if.master ctrl
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    BNE     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Unrecognised funct codes fall back to add; ALUWB still writes the result.
  function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
    case (f)
      6'b100000: return ALU_ADD;
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  state_e state_q;
  state_e state_d;
  state_e active_s;

  logic       iord_s;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regdst_s;
  logic       memtoreg_s;
  logic       regwrite_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic [2:0] alucontrol_s;
  logic [1:0] pcsrc_s;
  logic       pcwrite_s;
  logic       branch_s;
  logic       pc_update_s;
`ifdef MIPS_MC_BNE_EN
  logic       bne_s;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (ctrl.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_d = BNE;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (ctrl.op == OP_LW) begin
          state_d = MEMRD;
        end else if (ctrl.op == OP_SW) begin
          state_d = MEMWR;
        end else begin
          state_d = FETCH;
        end
      end
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // While reset is low the decoder shows FETCH; the write enables are masked below.
  always_comb begin
    active_s     = reset ? state_q : FETCH;
    iord_s       = 1'b0;
    memwrite_s   = 1'b0;
    irwrite_s    = 1'b0;
    regdst_s     = 1'b0;
    memtoreg_s   = 1'b0;
    regwrite_s   = 1'b0;
    alusrca_s    = 1'b0;
    alusrcb_s    = 2'b00;
    alucontrol_s = 3'b000;
    pcsrc_s      = 2'b00;
    pcwrite_s    = 1'b0;
    branch_s     = 1'b0;
`ifdef MIPS_MC_BNE_EN
    bne_s        = 1'b0;
`endif
    case (active_s)
      FETCH: begin
        irwrite_s    = 1'b1;
        pcwrite_s    = 1'b1;
        alusrcb_s    = 2'b01;
        alucontrol_s = ALU_ADD;
      end
      DECODE: begin
        alusrcb_s    = 2'b11;
        alucontrol_s = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = 2'b10;
        alucontrol_s = ALU_ADD;
      end
      MEMRD: iord_s = 1'b1;
      MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTE: begin
        alusrca_s    = 1'b1;
        alucontrol_s = funct_to_alu(ctrl.funct);
      end
      ALUWB: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
      end
      BRANCH: begin
        alusrca_s    = 1'b1;
        alucontrol_s = ALU_SUB;
        pcsrc_s      = 2'b01;
        branch_s     = 1'b1;
      end
      ADDIWB: regwrite_s = 1'b1;
      JUMP: begin
        pcsrc_s   = 2'b10;
        pcwrite_s = 1'b1;
      end
`ifdef MIPS_MC_BNE_EN
      BNE: begin
        alusrca_s    = 1'b1;
        alucontrol_s = ALU_SUB;
        pcsrc_s      = 2'b01;
        bne_s        = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    pc_update_s = pcwrite_s | (branch_s & ctrl.zero);
`ifdef MIPS_MC_BNE_EN
    pc_update_s = pc_update_s | (bne_s & ~ctrl.zero);
`endif
  end

  assign ctrl.iord       = iord_s;
  assign ctrl.memwrite   = memwrite_s & reset;
  assign ctrl.irwrite    = irwrite_s & reset;
  assign ctrl.regdst     = regdst_s;
  assign ctrl.memtoreg   = memtoreg_s;
  assign ctrl.regwrite   = regwrite_s & reset;
  assign ctrl.alusrca    = alusrca_s;
  assign ctrl.alusrcb    = alusrcb_s;
  assign ctrl.alucontrol = alucontrol_s;
  assign ctrl.pcsrc      = pcsrc_s;
  assign ctrl.pcen       = pc_update_s & reset;
  assign ctrl.state      = state_q;

endmodule
